// File: rtl/dec_regfile.sv
// dec_regfile
//   Parametrised register bank of 2**AW entries, WIDTH bits each. Writes are
//   steered by an AW-to-2**AW address decoder (the 3-to-8 decoder, widened).
//   Adds a registered read port, per-entry valid bits, an occupancy count
//   and a registered one-hot copy of the write strobe for downstream logging.
//
// Parameters
//   WIDTH  : data bits per entry
//   AW     : address width, DEPTH = 2**AW
//   BYPASS : 1 = same-cycle read of the address being written sees new data
//            0 = it sees the old contents
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset, highest priority
//   wr_en      in   write request
//   wr_addr    in   [AW-1:0] write index
//   wr_data    in   [WIDTH-1:0] write data
//   clr        in   synchronous clear of all entries and valid bits
//   rd_en      in   read request
//   rd_addr    in   [AW-1:0] read index
//   rd_data    out  [WIDTH-1:0] registered read data
//   rd_valid   out  registered valid bit of the entry read
//   rd_ack     out  one-cycle pulse, one cycle after an accepted read
//   wr_onehot  out  [DEPTH-1:0] registered decoded write strobe
//   valid_map  out  [DEPTH-1:0] per-entry valid bits
//   count      out  [AW:0] number of valid entries, 0..DEPTH
//   full       out  count == DEPTH
module dec_regfile #(
  parameter int WIDTH  = 8,
  parameter int AW     = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  rd_ack,
  output logic [(2**AW)-1:0]    wr_onehot,
  output logic [(2**AW)-1:0]    valid_map,
  output logic [AW:0]           count,
  output logic                  full
);

  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] wr_dec;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] rd_data_next;
  logic             rd_valid_next;
  logic             same_addr;

  // Address decoder: exactly one bit set when writing, all zero otherwise.
  always_comb begin
    wr_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == AW'(i))) begin
        wr_dec[i] = 1'b1;
      end
    end
  end

  // A clear wipes the bank first, so a coincident write always lands on an
  // empty bank and leaves exactly one valid entry. Without a clear, only a
  // write to an invalid entry grows the count, which is what keeps it from
  // exceeding DEPTH.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = wr_en ? (AW+1)'(1) : '0;
    end else if (wr_en && !valid_map[wr_addr]) begin
      count_next = count + (AW+1)'(1);
    end
  end

  // Read mux sees pre-edge state; the only exception is the same-address
  // bypass, which also holds when a clear is in progress.
  always_comb begin
    same_addr     = wr_en && (wr_addr == rd_addr);
    rd_data_next  = mem[rd_addr];
    rd_valid_next = valid_map[rd_addr];
    if (BYPASS && same_addr) begin
      rd_data_next  = wr_data;
      rd_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid_map <= '0;
      count     <= '0;
      wr_onehot <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_ack    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_dec[i]) begin
          mem[i] <= wr_data;
        end else if (clr) begin
          mem[i] <= '0;
        end
      end
      valid_map <= (clr ? '0 : valid_map) | wr_dec;
      count     <= count_next;
      wr_onehot <= wr_dec;
      rd_ack    <= rd_en;
      if (rd_en) begin
        rd_data  <= rd_data_next;
        rd_valid <= rd_valid_next;
      end
    end
  end

  assign full = (count == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_dec_regfile.sv
// tb_dec_regfile
//   Directed bench for dec_regfile (WIDTH=8, AW=3). Two instances share all
//   inputs: dut_b with BYPASS=1 and dut_n with BYPASS=0, so the same-address
//   read/write behaviour of both variants is exercised by one sequence.
module tb_dec_regfile;

  logic       clk = 1'b0;
  logic       rst, wr_en, clr, rd_en;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  logic [7:0] rd_data_b, rd_data_n;
  logic       rd_valid_b, rd_valid_n, rd_ack_b, rd_ack_n;
  logic [7:0] wr_onehot_b, wr_onehot_n, valid_map_b, valid_map_n;
  logic [3:0] count_b, count_n;
  logic       full_b, full_n;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dec_regfile #(.WIDTH(8), .AW(3), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .rd_ack(rd_ack_b), .wr_onehot(wr_onehot_b),
    .valid_map(valid_map_b), .count(count_b), .full(full_b)
  );

  dec_regfile #(.WIDTH(8), .AW(3), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_valid(rd_valid_n), .rd_ack(rd_ack_n), .wr_onehot(wr_onehot_n),
    .valid_map(valid_map_n), .count(count_n), .full(full_n)
  );

  // Drive one cycle of inputs, let the rising edge take them, then settle
  // 1 time unit past the edge before anything is sampled.
  task automatic applyStimulus(input logic r, input logic we, input logic [2:0] wa,
                               input logic [7:0] wd, input logic re,
                               input logic [2:0] ra, input logic c);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Checks common to both instances, which must agree on everything except
  // the bypassed read data.
  task automatic checkState(input string tag, input logic [3:0] exp_count,
                            input logic exp_full, input logic [7:0] exp_vmap,
                            input logic [7:0] exp_onehot);
    checkOutput({tag, ".count"},     32'(count_b),     32'(exp_count));
    checkOutput({tag, ".full"},      32'(full_b),      32'(exp_full));
    checkOutput({tag, ".valid_map"}, 32'(valid_map_b), 32'(exp_vmap));
    checkOutput({tag, ".wr_onehot"}, 32'(wr_onehot_b), 32'(exp_onehot));
    checkOutput({tag, ".count_n"},   32'(count_n),     32'(exp_count));
    checkOutput({tag, ".vmap_n"},    32'(valid_map_n), 32'(exp_vmap));
  endtask

  task automatic checkRead(input string tag, input logic exp_ack,
                           input logic [7:0] exp_data_b, input logic exp_valid_b,
                           input logic [7:0] exp_data_n, input logic exp_valid_n);
    checkOutput({tag, ".rd_ack"},     32'(rd_ack_b),   32'(exp_ack));
    checkOutput({tag, ".rd_ack_n"},   32'(rd_ack_n),   32'(exp_ack));
    checkOutput({tag, ".rd_data"},    32'(rd_data_b),  32'(exp_data_b));
    checkOutput({tag, ".rd_valid"},   32'(rd_valid_b), 32'(exp_valid_b));
    checkOutput({tag, ".rd_data_n"},  32'(rd_data_n),  32'(exp_data_n));
    checkOutput({tag, ".rd_valid_n"}, 32'(rd_valid_n), 32'(exp_valid_n));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr = 1'b0;
    #2;

    // Reset state
    applyStimulus(1, 0, 3'd0, 8'h00, 0, 3'd0, 0);
    checkState("reset", 4'd0, 1'b0, 8'h00, 8'h00);
    checkRead("reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Read of a never-written entry
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd5, 0);
    checkRead("rd_empty5", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    checkState("rd_empty5", 4'd0, 1'b0, 8'h00, 8'h00);

    // Write A5 to addr 2; no read so rd_ack drops and read data holds
    applyStimulus(0, 1, 3'd2, 8'hA5, 0, 3'd0, 0);
    checkState("wr2", 4'd1, 1'b0, 8'h04, 8'h04);
    checkRead("wr2_hold", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd2, 0);
    checkRead("rd2", 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1);
    checkState("rd2", 4'd1, 1'b0, 8'h04, 8'h00);

    // Preload addr 7 with 11, then same-cycle write 3C + read addr 7
    applyStimulus(0, 1, 3'd7, 8'h11, 0, 3'd0, 0);
    checkState("wr7", 4'd2, 1'b0, 8'h84, 8'h80);
    applyStimulus(0, 1, 3'd7, 8'h3C, 1, 3'd7, 0);
    checkRead("bypass7", 1'b1, 8'h3C, 1'b1, 8'h11, 1'b1);
    checkState("bypass7", 4'd2, 1'b0, 8'h84, 8'h80);

    // Write to a different address does not disturb the read
    applyStimulus(0, 1, 3'd3, 8'h77, 1, 3'd2, 0);
    checkRead("diffaddr", 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1);
    checkState("diffaddr", 4'd3, 1'b0, 8'h8C, 8'h08);

    // Plain clear with a read: read returns pre-clear contents of addr 7
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd7, 1);
    checkRead("clr_rd7", 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1);
    checkState("clr", 4'd0, 1'b0, 8'h00, 8'h00);

    // Fill the bank with data = addr
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'(i), 8'(i), 0, 3'd0, 0);
      checkState($sformatf("fill%0d", i), 4'(i + 1), (i == 7), 8'((16'd1 << (i + 1)) - 16'd1),
                 8'(8'd1 << i));
    end

    // Overwrite on a full bank keeps count and full
    applyStimulus(0, 1, 3'd0, 8'hFF, 0, 3'd0, 0);
    checkState("rewrite0", 4'd8, 1'b1, 8'hFF, 8'h01);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd0, 0);
    checkRead("rd0_ff", 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd5, 0);
    checkRead("rd5", 1'b1, 8'h05, 1'b1, 8'h05, 1'b1);

    // Clear + write 5A to addr 4 on a full bank, reading addr 3 pre-edge
    applyStimulus(0, 1, 3'd4, 8'h5A, 1, 3'd3, 1);
    checkState("clr_wr4", 4'd1, 1'b0, 8'h10, 8'h10);
    checkRead("clr_wr4_rd3", 1'b1, 8'h03, 1'b1, 8'h03, 1'b1);

    // Clear + write with same-address read: bypass still applies
    applyStimulus(0, 1, 3'd4, 8'h66, 1, 3'd4, 1);
    checkRead("clr_byp4", 1'b1, 8'h66, 1'b1, 8'h5A, 1'b1);
    checkState("clr_byp4", 4'd1, 1'b0, 8'h10, 8'h10);

    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd3, 0);
    checkRead("rd3_cleared", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd4, 0);
    checkRead("rd4_after", 1'b1, 8'h66, 1'b1, 8'h66, 1'b1);

    // Reset with simultaneous read and write: both dropped
    applyStimulus(0, 1, 3'd6, 8'h21, 0, 3'd0, 0);
    checkState("pre_rst", 4'd2, 1'b0, 8'h50, 8'h40);
    applyStimulus(1, 1, 3'd1, 8'h99, 1, 3'd4, 0);
    checkState("rst_mid", 4'd0, 1'b0, 8'h00, 8'h00);
    checkRead("rst_mid", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Every entry reads back as zero / invalid after reset
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'(i), 0);
      checkRead($sformatf("post_rst_rd%0d", i), 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    end

    // Fresh bank behaviour after reset
    applyStimulus(0, 1, 3'd6, 8'h42, 0, 3'd0, 0);
    checkState("fresh_wr6", 4'd1, 1'b0, 8'h40, 8'h40);
    checkRead("fresh_wr6", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd6, 0);
    checkRead("fresh_rd6", 1'b1, 8'h42, 1'b1, 8'h42, 1'b1);

    applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dec_regfile.md
Name: dec_regfile

Overview:
- Parametrised register bank of 2**AW entries, each WIDTH bits wide.
- Writes are steered by an internal address decoder that generalises the 3-to-8 decoder to AW-to-2**AW.
- Provides a registered read port, per-entry valid tracking, an occupancy count and a registered one-hot write strobe for downstream logging.
- Serves as the generic storage primitive for later datapath labs, replacing hand-instantiated banks of D flip-flops.

Parameters:
- WIDTH, 8: data bits per entry.
- AW, 3: address width; depth DEPTH = 2**AW.
- BYPASS, 1: 1 = a same-cycle read of the address being written returns the new write data; 0 = it returns the old contents.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_addr  input  AW  write entry index.
- wr_data  input  WIDTH  write data.
- clr  input  1  synchronous clear of all entries and valid bits.
- rd_en  input  1  read request.
- rd_addr  input  AW  read entry index.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  registered valid bit of the entry read.
- rd_ack  output  1  high for exactly one cycle per accepted read, 1 cycle after rd_en.
- wr_onehot  output  DEPTH  registered decoded write strobe: (1<<wr_addr) if wr_en, else 0.
- valid_map  output  DEPTH  per-entry valid bits.
- count  output  AW+1  number of valid entries, range 0..DEPTH.
- full  output  1  count == DEPTH, combinational from count.

Behaviour:
- Reset (rst=1 at a rising edge) has priority over all other inputs. It forces all entries, valid_map, rd_data, rd_valid, rd_ack, wr_onehot and count to 0; full=0.
- Write: if wr_en=1 at the edge, entry[wr_addr] <= wr_data and valid_map[wr_addr] <= 1. Rewriting an already-valid entry overwrites the data and leaves count unchanged.
- wr_onehot: one-cycle latency. Equals 1<<wr_addr the cycle after a write and 0 the cycle after no write. Exactly one bit is set whenever it is non-zero.
- Read: if rd_en=1 at edge N, then after edge N:
  - rd_ack=1;
  - rd_data = entry[rd_addr] as held before edge N;
  - rd_valid = valid_map[rd_addr] as held before edge N.
- No rd_en: rd_ack=0 and rd_data/rd_valid hold their last values.
- Read of a never-written entry returns rd_data=0, rd_valid=0.
- Read and write to the same address in the same cycle:
  - BYPASS=1: rd_data=wr_data and rd_valid=1.
  - BYPASS=0: old data and old valid bit.
  - Different addresses: the read is unaffected.
- clr=1 at an edge: all entries and valid bits go to 0, and count goes to 0.
  - If wr_en is also 1, the write is applied after the clear. That entry holds wr_data with valid=1, count=1, and wr_onehot reports the write normally.
  - A simultaneous read returns pre-edge state, except that the BYPASS rule still applies to the same-address write.
- count: +1 when a write targets an invalid entry and clr=0; otherwise unchanged by writes. It saturates at DEPTH by construction, never wraps, and there is no decrement other than clr/rst.
- full: asserted while count==DEPTH. Writes are still accepted when full (overwrite semantics), with no stall and no error.
- Address width: wr_addr/rd_addr always index within range; all DEPTH values are legal.
- Reset mid-operation: a read requested in the same cycle as rst is dropped, giving rd_ack=0 the next cycle. The cycle after reset behaves as a fresh bank.

Test Plan:
- Reset then read addr 5 (WIDTH=8, AW=3) -> next cycle rd_ack=1, rd_data=8'h00, rd_valid=0, count=0, full=0.
- Write 8'hA5 to addr 2, then read addr 2 -> wr_onehot=8'b0000_0100 the cycle after the write; read gives rd_data=8'hA5, rd_valid=1, count=1.
- Same-cycle write 8'h3C and read at addr 7 holding 8'h11 -> BYPASS=1: rd_data=8'h3C, rd_valid=1. BYPASS=0: rd_data=8'h11.
- Write all 8 addresses with data=addr, then rewrite addr 0 with 8'hFF -> count=8 and full=1 after the 8th write; count stays 8 after the rewrite; read addr 0 gives 8'hFF.
- clr with simultaneous write 8'h5A to addr 4 on a full bank -> valid_map=8'b0001_0000, count=1, full=0; read addr 3 gives rd_data=0, rd_valid=0.
- rst asserted in the same cycle as rd_en and wr_en -> next cycle rd_ack=0, wr_onehot=0, count=0, and all entries read back as 0.
